bk_addsub_pipe: RTL

BK_ADDSUB_PIPE -- requirements
Module: bk_addsub_pipe

---
 rtl/bk_pkg.sv | 75 +++++++
 rtl/bk_prefix_cell.sv | 18 +
 rtl/bk_addsub_pipe.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bk_pkg.sv
// Shared helpers for the Brent-Kung add/sub pipeline: legal parameter
// ranges, prefix-tree geometry and pipeline-register placement.
package bk_pkg;

    localparam int unsigned BK_N_MIN      = 8;
    localparam int unsigned BK_N_MAX      = 64;
    localparam int unsigned BK_STAGES_MIN = 1;
    localparam int unsigned BK_STAGES_MAX = 4;

    // Operand width must be a power of two inside the supported range.
    function automatic bit bk_n_legal(input int unsigned n);
        return (n >= BK_N_MIN) && (n <= BK_N_MAX) && ((n & (n - 1)) == 0);
    endfunction

    // Pipeline depth must be inside the supported range.
    function automatic bit bk_stages_legal(input int unsigned stages);
        return (stages >= BK_STAGES_MIN) && (stages <= BK_STAGES_MAX);
    endfunction

    // Number of prefix levels: log2(n) up-sweep plus log2(n)-1 down-sweep.
    function automatic int unsigned bk_levels(input int unsigned n);
        return 2 * $clog2(n) - 1;
    endfunction

    // Level after which register k (0-based) sits. Register 0 always follows
    // g/p generation (level 0); the rest are spread evenly over the tree.
    function automatic int unsigned bk_bound(input int unsigned n,
                                             input int unsigned stages,
                                             input int unsigned k);
        return (k == 0) ? 0 : (k * bk_levels(n)) / stages;
    endfunction

    // Returns 1 + register index when a register follows level lvl, else 0.
    function automatic int unsigned bk_stage_at(input int unsigned n,
                                                input int unsigned stages,
                                                input int unsigned lvl);
        for (int unsigned k = 0; k < stages; k++) begin
            if (bk_bound(n, stages, k) == lvl) begin
                return k + 1;
            end
        end
        return 0;
    endfunction

    // True when bit i holds a prefix cell at level lvl (1-based levels).
    function automatic bit bk_is_node(input int unsigned n,
                                      input int unsigned lvl,
                                      input int unsigned i);
        int unsigned l;
        int unsigned s;
        l = $clog2(n);
        if (lvl == 0 || lvl > 2 * l - 1) begin
            return 1'b0;
        end
        if (lvl <= l) begin
            s = 1 << lvl;
            return ((i + 1) % s) == 0;
        end
        s = 1 << (2 * l - lvl);
        return (((i + 1) % s) == (s / 2)) && ((i + 1) > s);
    endfunction

    // Lower-significance partner bit of the cell at (lvl, i).
    function automatic int unsigned bk_partner(input int unsigned n,
                                               input int unsigned lvl,
                                               input int unsigned i);
        int unsigned l;
        l = $clog2(n);
        if (lvl <= l) begin
            return i - (1 << (lvl - 1));
        end
        return i - ((1 << (2 * l - lvl)) >> 1);
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung prefix operator: merges a high (g,p) group with the adjacent
// lower group.
module bk_prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_o,
    output logic p_o
);

    // Group generate / propagate combine.
    always_comb begin
        g_o = g_hi | (p_hi & g_lo);
        p_o = p_hi & p_lo;
    end

endmodule

// File: rtl/bk_addsub_pipe.sv
// Pipelined N-bit adder/subtractor with a Brent-Kung carry tree and a
// valid/ready handshake. Stage registers sit after g/p generation and at
// evenly spaced prefix levels; the sum XOR and flags follow the last one.
module bk_addsub_pipe
    import bk_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned NL   = bk_levels(N);
    localparam int unsigned SW   = N + 3;
    localparam int unsigned LAST = STAGES - 1;

    if (!bk_n_legal(N)) begin : g_bad_n
        $error("bk_addsub_pipe: N must be a power of two in 8..64");
    end
    if (!bk_stages_legal(STAGES)) begin : g_bad_stages
        $error("bk_addsub_pipe: STAGES must be in 1..4");
    end

    // ---------------- handshake / valid chain ----------------
    logic [STAGES:0]   rdy;
    logic [STAGES:0]   v_in;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] v_q;

    // A stage may load when empty or when its downstream neighbour advances.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
        v_in = {v_q, in_valid};
        v_d  = v_q;
        for (int k = 0; k < int'(STAGES); k++) begin
            if (rdy[k]) begin
                v_d[k] = v_in[k];
            end
        end
    end

    // Per-stage valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready = rdy[0] & ~rst;

    // ---------------- g/p generation ----------------
    logic [N-1:0]  b_eff;
    logic          c0;
    logic [N-1:0]  gen_g;
    logic [N-1:0]  gen_p;
    logic [SW-1:0] gen_s;

    // Effective operand, carry-in folded into bit-0 generate; the half sum
    // and sign bits ride alongside the tree for the final XOR and flags.
    always_comb begin
        b_eff    = sub ? ~b : b;
        c0       = sub ? 1'b1 : cin;
        gen_p    = a ^ b_eff;
        gen_g    = a & b_eff;
        gen_g[0] = gen_g[0] | (gen_p[0] & c0);
        gen_s    = {b_eff[N-1], a[N-1], c0, gen_p};
    end

    // ---------------- prefix tree with interleaved registers ----------------
    for (genvar lvl = 0; lvl <= int'(NL); lvl++) begin : g_lv
        localparam int unsigned STG = bk_stage_at(N, STAGES, lvl);

        logic [N-1:0]  g_d;
        logic [N-1:0]  p_d;
        logic [SW-1:0] s_d;
        logic [N-1:0]  g_o;
        logic [N-1:0]  p_o;
        logic [SW-1:0] s_o;

        if (lvl == 0) begin : g_gen
            assign g_d = gen_g;
            assign p_d = gen_p;
            assign s_d = gen_s;
        end else begin : g_tree
            assign s_d = g_lv[lvl-1].s_o;
            for (genvar i = 0; i < int'(N); i++) begin : g_bit
                if (bk_is_node(N, lvl, i)) begin : g_cell
                    localparam int unsigned LO = bk_partner(N, lvl, i);
                    bk_prefix_cell u_cell (
                        .g_hi (g_lv[lvl-1].g_o[i]),
                        .p_hi (g_lv[lvl-1].p_o[i]),
                        .g_lo (g_lv[lvl-1].g_o[LO]),
                        .p_lo (g_lv[lvl-1].p_o[LO]),
                        .g_o  (g_d[i]),
                        .p_o  (p_d[i])
                    );
                end else begin : g_pass
                    assign g_d[i] = g_lv[lvl-1].g_o[i];
                    assign p_d[i] = g_lv[lvl-1].p_o[i];
                end
            end
        end

        if (STG != 0) begin : g_reg
            logic [N-1:0]  g_q;
            logic [N-1:0]  p_q;
            logic [SW-1:0] s_q;

            // Stage register: holds while its slot is full and stalled.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    g_q <= '0;
                    p_q <= '0;
                    s_q <= '0;
                end else if (rdy[STG-1]) begin
                    g_q <= g_d;
                    p_q <= p_d;
                    s_q <= s_d;
                end
            end

            assign g_o = g_q;
            assign p_o = p_q;
            assign s_o = s_q;
        end else begin : g_wire
            assign g_o = g_d;
            assign p_o = p_d;
            assign s_o = s_d;
        end
    end

    // ---------------- sum and flags ----------------
    logic [N-1:0] g_fin;
    logic [N-1:0] hs_fin;
    logic         c0_fin;
    logic         am_fin;
    logic         bm_fin;
    logic [N-1:0] prefix_p_unused;
    logic [N-1:0] carry;
    logic [N-1:0] sum_raw;

    assign g_fin                            = g_lv[NL].g_o;
    assign {bm_fin, am_fin, c0_fin, hs_fin} = g_lv[NL].s_o;
    // Group propagate of completed prefixes has no consumer.
    assign prefix_p_unused                  = g_lv[NL].p_o;

    // Final XOR and flags; an empty output slot presents all zeros.
    always_comb begin
        carry     = {g_fin[N-2:0], c0_fin};
        sum_raw   = hs_fin ^ carry;
        out_valid = v_q[LAST];
        sum       = '0;
        cout      = 1'b0;
        ovf       = 1'b0;
        zero      = 1'b0;
        if (v_q[LAST]) begin
            sum  = sum_raw;
            cout = g_fin[N-1];
            ovf  = (am_fin ~^ bm_fin) & (sum_raw[N-1] ^ am_fin);
            zero = (sum_raw == '0);
        end
    end

endmodule
